// File: rtl/cdc_read_responder_pkg.sv
// Package shared by the clk50 read responder and its clk100 initiator.
// Contents: responder state encodings, default synchroniser depth and the
// four-phase handshake phase names.
package cdc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam int SYNC_DEPTH_DEF = 2;

  // Four-phase handshake as seen by either side of the crossing.
  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,  // req low, ack low
    PH_REQ     = 2'd1,  // req high, ack low
    PH_ACK     = 2'd2,  // req high, ack high
    PH_RELEASE = 2'd3   // req low, ack high
  } hs_phase_e;

endpackage

// File: rtl/cdc_read_responder_if.sv
// Read request/acknowledge handshake between the clk100 initiator and the
// clk50 responder.
//   read_f : request level (initiator -> responder), asynchronous to clk50
//   addr_f : request address, held stable while read_f is high
//   ack_s  : acknowledge level (responder -> initiator)
//   data_s : read data, valid while ack_s is high
//   err_s  : read timed out, valid while ack_s is high
interface cdc_read_responder_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic              read_f;
  logic [ADDR_W-1:0] addr_f;
  logic              ack_s;
  logic [DATA_W-1:0] data_s;
  logic              err_s;

  modport master (output read_f, addr_f, input ack_s, data_s, err_s);
  modport slave  (input read_f, addr_f, output ack_s, data_s, err_s);
endinterface

// File: rtl/cdc_read_responder_sync_bit.sv
// Single-bit level synchroniser with asynchronous active-low clear.
//   clk50   : destination clock
//   reset_n : asynchronous active-low clear of every stage
//   d       : asynchronous input level
//   q       : d after SYNC_STAGES flip-flops
// Depths below 2 are raised to 2; a single flop is not a synchroniser.
module sync_bit
  import cdc_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_DEPTH_DEF
) (
  input  logic clk50,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  localparam int DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [DEPTH-1:0] sync_p;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[DEPTH-2:0], d};
    end
  end

  assign q = sync_p[DEPTH-1];

endmodule

// File: rtl/cdc_read_responder.sv
// clk50-side responder of the four-phase read handshake from clk100.
// Synchronises read_f, issues one memory read, returns data with ack_s and
// holds ack_s until the request is withdrawn.
//   clk50     : only clock
//   reset_n   : asynchronous active-low reset
//   hs        : handshake (read_f/addr_f in, ack_s/data_s/err_s out)
//   busy      : high in WAIT and ACK
//   mem_rd    : memory read strobe, held until mem_ready
//   mem_addr  : memory address, stable while mem_rd is high
//   mem_ready : memory accept / data valid
//   mem_data  : read data, valid with mem_ready
module cdc_read_responder
  import cdc_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = SYNC_DEPTH_DEF,
  parameter int TIMEOUT     = 255
) (
  input  logic                clk50,
  input  logic                reset_n,
  cdc_read_responder_if.slave hs,
  output logic                busy,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_data
);

  // TIMEOUT = 0 still gets a 1-bit timer so the declaration stays legal.
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  logic             req_s;
  logic [1:0]       state;
  logic [TMR_W-1:0] timer;

  sync_bit #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk50   (clk50),
    .reset_n (reset_n),
    .d       (hs.read_f),
    .q       (req_s)
  );

  // addr_f is quasi-static while read_f is high, so it is captured directly
  // once the synchronised request is seen.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      hs.ack_s  <= 1'b0;
      hs.data_s <= '0;
      hs.err_s  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_s) begin
            mem_addr <= hs.addr_f;
            mem_rd   <= 1'b1;
            hs.err_s <= 1'b0;
            timer    <= '0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // mem_ready wins over a timeout landing on the same edge. A
          // withdrawn request does not abort the read.
          if (mem_ready) begin
            hs.data_s <= mem_data;
            mem_rd    <= 1'b0;
            hs.ack_s  <= 1'b1;
            state     <= ST_ACK;
          end else if ((TIMEOUT != 0) && (timer == TMR_LAST)) begin
            hs.data_s <= '0;
            hs.err_s  <= 1'b1;
            mem_rd    <= 1'b0;
            hs.ack_s  <= 1'b1;
            state     <= ST_ACK;
          end else if (timer != TMR_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        ST_ACK: begin
          // A re-raised request is only honoured after returning to IDLE.
          if (!req_s) begin
            hs.ack_s <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_WAIT) || (state == ST_ACK);

endmodule

// File: tb/tb_cdc_read_responder.sv
module tb_cdc_read_responder;

  logic        clk50 = 1'b0;
  logic        reset_n;
  logic        busy;
  logic        mem_rd;
  logic [23:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  int wait_n;
  int wcnt;
  int checks   = 0;
  int failures = 0;

  always #10 clk50 = ~clk50;

  cdc_read_responder_if #(.ADDR_W(24), .DATA_W(32)) hs ();

  cdc_read_responder #(
    .ADDR_W      (24),
    .DATA_W      (32),
    .SYNC_STAGES (2),
    .TIMEOUT     (8)
  ) dut (
    .clk50     (clk50),
    .reset_n   (reset_n),
    .hs        (hs),
    .busy      (busy),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_data  (mem_data)
  );

  // Memory model: accepts after wait_n wait cycles of mem_rd being high.
  function automatic logic [31:0] mem_model(input logic [23:0] a);
    return (a == 24'h001234) ? 32'hDEADBEEF : {~a[7:0], a};
  endfunction

  assign mem_data  = mem_model(mem_addr);
  assign mem_ready = mem_rd && (wcnt == wait_n);

  always @(posedge clk50 or negedge reset_n) begin
    if (!reset_n)     wcnt <= 0;
    else if (!mem_rd) wcnt <= 0;
    else              wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic do_read(input logic [23:0] a, input int wn,
                         output int t_rd, output int n_rd, output int t_ack);
    wait_n = wn;
    hs.addr_f = a;
    hs.read_f = 1'b1;
    t_rd = -1; n_rd = 0; t_ack = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mem_rd) begin
        n_rd++;
        if (t_rd < 0) t_rd = i;
      end
      if (hs.ack_s) begin
        t_ack = i;
        break;
      end
    end
  endtask

  task automatic do_release(output int t_fall);
    hs.read_f = 1'b0;
    t_fall = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!hs.ack_s) begin
        t_fall = i;
        break;
      end
    end
  endtask

  initial begin
    int t_rd, n_rd, t_ack, t_fall, cnt;
    logic [23:0] a;

    hs.read_f = 1'b0;
    hs.addr_f = '0;
    wait_n    = 0;
    reset_n   = 1'b1;
    #3 reset_n = 1'b0;
    #22;
    chk("rst_ack", hs.ack_s, 0);
    chk("rst_err", hs.err_s, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", hs.data_s, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(posedge clk50); #1 reset_n = 1'b1;
    tick();

    // Normal read, 3 wait cycles
    do_read(24'h001234, 3, t_rd, n_rd, t_ack);
    chk("norm_t_rd", t_rd, 3);
    chk("norm_n_rd", n_rd, 4);
    chk("norm_t_ack", t_ack, 7);
    chk("norm_addr", mem_addr, 24'h001234);
    chk("norm_data", hs.data_s, 32'hDEADBEEF);
    chk("norm_err", hs.err_s, 0);
    chk("norm_busy", busy, 1);
    do_release(t_fall);
    chk("norm_t_fall", t_fall, 3);
    chk("norm_busy_end", busy, 0);
    chk("norm_data_hold", hs.data_s, 32'hDEADBEEF);

    // Zero-wait memory
    do_read(24'h000042, 0, t_rd, n_rd, t_ack);
    chk("zw_t_rd", t_rd, 3);
    chk("zw_n_rd", n_rd, 1);
    chk("zw_t_ack", t_ack, 4);
    chk("zw_data", hs.data_s, 32'hBD000042);
    do_release(t_fall);
    chk("zw_t_fall", t_fall, 3);

    // Timeout (TIMEOUT=8), then a good read clears err_s
    do_read(24'h000100, 100, t_rd, n_rd, t_ack);
    chk("to_t_rd", t_rd, 3);
    chk("to_n_rd", n_rd, 8);
    chk("to_t_ack", t_ack, 11);
    chk("to_err", hs.err_s, 1);
    chk("to_data", hs.data_s, 0);
    chk("to_mem_rd", mem_rd, 0);
    do_release(t_fall);
    chk("to_t_fall", t_fall, 3);
    chk("to_err_hold", hs.err_s, 1);
    do_read(24'h000101, 1, t_rd, n_rd, t_ack);
    chk("to2_t_ack", t_ack, 5);
    chk("to2_err", hs.err_s, 0);
    chk("to2_data", hs.data_s, 32'hFE000101);
    do_release(t_fall);
    chk("to2_t_fall", t_fall, 3);

    // Early withdrawal during WAIT
    wait_n = 5;
    hs.addr_f = 24'h000777;
    hs.read_f = 1'b1;
    cnt = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (mem_rd) begin cnt = i; break; end
    end
    chk("ew_t_rd", cnt, 3);
    hs.read_f = 1'b0;
    cnt = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (hs.ack_s) begin cnt = i; break; end
    end
    chk("ew_t_ack", cnt, 6);
    chk("ew_data", hs.data_s, 32'h88000777);
    tick();
    chk("ew_ack_pulse", hs.ack_s, 0);
    chk("ew_busy", busy, 0);
    do_read(24'h000ABC, 2, t_rd, n_rd, t_ack);
    chk("ew2_t_ack", t_ack, 6);
    chk("ew2_data", hs.data_s, 32'h43000ABC);
    do_release(t_fall);
    chk("ew2_t_fall", t_fall, 3);

    // Asynchronous reset mid-read
    wait_n = 100;
    hs.addr_f = 24'h000555;
    hs.read_f = 1'b1;
    repeat (4) tick();
    chk("mr_mem_rd_pre", mem_rd, 1);
    #5 reset_n = 1'b0;
    #1;
    chk("mr_mem_rd", mem_rd, 0);
    chk("mr_ack", hs.ack_s, 0);
    chk("mr_busy", busy, 0);
    chk("mr_mem_addr", mem_addr, 0);
    wait_n = 0;
    @(posedge clk50); #1 reset_n = 1'b1;
    cnt = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (mem_rd) begin cnt = i; break; end
    end
    chk("mr_t_rd", cnt, 3);
    chk("mr_addr", mem_addr, 24'h000555);
    tick();
    chk("mr_ack_done", hs.ack_s, 1);
    chk("mr_data", hs.data_s, 32'hAA000555);
    do_release(t_fall);
    chk("mr_t_fall", t_fall, 3);

    // Back-to-back handshakes at random read_f phases
    for (int k = 0; k < 5; k++) begin
      a = 24'($urandom) & 24'hFFFFFF;
      wait_n = int'($urandom_range(0, 3));
      #($urandom_range(1, 18));
      hs.addr_f = a;
      hs.read_f = 1'b1;
      cnt = -1;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk50); #1;
        if (hs.ack_s) begin cnt = i; break; end
      end
      chk("b2b_ack_seen", (cnt > 0), 1);
      chk("b2b_data", hs.data_s, mem_model(a));
      chk("b2b_err", hs.err_s, 0);
      repeat ($urandom_range(0, 2)) tick();
      chk("b2b_ack_steady", hs.ack_s, 1);
      #($urandom_range(1, 18));
      hs.read_f = 1'b0;
      cnt = -1;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk50); #1;
        if (!hs.ack_s) begin cnt = i; break; end
      end
      chk("b2b_ack_fall", (cnt > 0), 1);
      tick();
      chk("b2b_ack_low", hs.ack_s, 0);
      chk("b2b_idle", busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_read_responder.md
# cdc_read_responder

Slow-domain (clk50) responder for the four-phase read request/acknowledge handshake that crosses from the clk100 domain. It synchronises the level request `read_f`, performs one read on the clk50-side memory port, returns the data with a level acknowledge `ack_s`, and holds the acknowledge until the request is withdrawn. It sits at the clk50 end of the read path; the clk100 initiator owns `read_f` and the address and reads back `ack_s` and the data.

## Interface
- `ADDR_W`, 24: width of the request address and the memory address.
- `DATA_W`, 32: width of the read data.
- `SYNC_STAGES`, 2: flip-flop stages in the request synchroniser; minimum 2.
- `TIMEOUT`, 255: maximum clk50 cycles to wait for `mem_ready`; 0 disables the timeout.

- `clk50`  in  1: the only clock; all state is registered on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `read_f`  in  1: request level from clk100; asynchronous to `clk50`.
- `addr_f`  in  ADDR_W: request address; the initiator holds it stable while `read_f` is high, so it is quasi-static and is not synchronised.
- `ack_s`  out  1: acknowledge level; registered, glitch-free.
- `data_s`  out  DATA_W: read data; valid and stable while `ack_s` is high.
- `err_s`  out  1: set with `ack_s` when the read timed out.
- `busy`  out  1: high in the WAIT and ACK states.
- `mem_rd`  out  1: memory read strobe, held until accepted.
- `mem_addr`  out  ADDR_W: memory address, stable while `mem_rd` is high.
- `mem_ready`  in  1: memory accept/data-valid; sampled only on edges where `mem_rd` is high.
- `mem_data`  in  DATA_W: read data; valid in the cycle `mem_ready` is high.

## Operation
- `req_s` is `read_f` after `SYNC_STAGES` flip-flops. All control logic uses `req_s` only.
- The state machine has three states: IDLE, WAIT and ACK.
- **IDLE**
  - On `req_s`=1: capture `addr_f` into `mem_addr`; set `mem_rd`=1; clear `err_s`; clear the timer; go to WAIT.
- **WAIT**
  - On `mem_ready`=1: load `mem_data` into `data_s`; set `mem_rd`=0 and `ack_s`=1; go to ACK.
  - Otherwise, if `TIMEOUT`≠0 and timer == `TIMEOUT`-1: set `mem_rd`=0, `data_s`=0, `err_s`=1 and `ack_s`=1; go to ACK.
  - Otherwise increment the timer. The timer is `$clog2(TIMEOUT+1)` bits wide and saturates; it never wraps.
- **ACK**
  - On `req_s`=0: set `ack_s`=0 and go to IDLE. `data_s` and `err_s` keep their values until the next capture.
- Timeout has priority only when `mem_ready` is 0. If `mem_ready` arrives on the timeout cycle, the read completes normally with `err_s`=0.
- If `req_s` falls while in WAIT (protocol violation), the read still completes. In ACK, `req_s`=0 is seen on the next edge, so `ack_s` is a one-cycle pulse.
- If `req_s` rises again while in ACK, it is ignored; a new read starts only from IDLE. A request that is still high on return to IDLE starts a new read.
- Reset (asynchronous, including mid-read):
  - `ack_s`=0, `err_s`=0, `mem_rd`=0, `busy`=0, `data_s`=0, `mem_addr`=0.
  - Synchroniser stages cleared, state = IDLE, timer = 0.
  - An in-flight memory read is abandoned; the memory side must tolerate `mem_rd` dropping.

## Timing
- `read_f` rise to `mem_rd`=1: `SYNC_STAGES`+1 edges of `clk50`.
- `mem_ready` sampled high at edge k: `ack_s`=1 and `mem_rd`=0 after edge k. This is one cycle; there is no combinational path from `mem_ready` to the outputs.
- Zero-wait memory (`mem_ready`=1 on the first WAIT cycle): `read_f` rise to `ack_s` takes `SYNC_STAGES`+2 edges.
- Timeout: `ack_s`=1 exactly `TIMEOUT` cycles after `mem_rd` first goes high.
- `read_f` fall to `ack_s`=0: `SYNC_STAGES`+1 edges.
- Minimum full cycle at `SYNC_STAGES`=2, zero-wait memory, initiator responding on its next clk100 edge: roughly 8 `clk50` cycles.
- `ack_s`, `data_s` and `err_s` all change on the same edge, so the initiator may sample data on the synchronised rise of `ack_s`.

## Structure
- Shared package `cdc_pkg`:
  - state encodings `ST_IDLE`, `ST_WAIT`, `ST_ACK`;
  - the default synchroniser depth constant;
  - the handshake phase names, shared with the clk100 initiator.
- One sub-module, `sync_bit`: parameterised `SYNC_STAGES`-deep single-bit synchroniser with asynchronous active-low clear. The matching initiator reuses it for `ack_s`.
- The top level holds the state machine, timer, address and data registers.

## Test plan
- **Normal read:** reset, `addr_f`=24'h00_1234, `read_f`=1, memory returns 32'hDEADBEEF after 3 wait cycles → `mem_addr`=24'h00_1234 with `mem_rd` high for 4 cycles; `ack_s`=1 with `data_s`=32'hDEADBEEF and `err_s`=0; `ack_s`=0 three edges after `read_f`=0.
- **Zero-wait:** `mem_ready` tied 1 → `ack_s` rises 4 edges after `read_f` rises; `mem_rd` is high for exactly 1 cycle.
- **Timeout:** `TIMEOUT`=8, `mem_ready`=0 → `mem_rd` high for 8 cycles, then `ack_s`=1, `err_s`=1, `data_s`=0. The next good read clears `err_s`.
- **Early withdrawal:** `read_f` dropped during WAIT, `mem_ready` later → the read completes and `ack_s` pulses for 1 cycle; a second read then works.
- **Mid-read reset:** `reset_n`=0 asynchronously during WAIT → `mem_rd`, `ack_s` and `busy` go to 0 immediately; after release, with `read_f` high, a new read is issued 3 edges later.
- **Back-to-back:** five consecutive handshakes at random `read_f` phase offsets against `clk50` → every `data_s` matches the memory model and no `ack_s` glitches occur.
